// File: rtl/pmod_dac_rx.sv
// pmod_dac_rx: listening end of the PMOD DAC serial link.
// Oversamples CS_N/SCLK/DIN/LDAC_N on S_AXI_ACLK, deserializes MSB-first
// frames, reports good frames and the word transferred by LDAC_N.
module pmod_dac_rx #(
    parameter int FRAME_BITS = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  dac_cs_n,
    input  logic                  dac_sclk,
    input  logic                  dac_din,
    input  logic                  dac_ldac_n,
    input  logic                  err_clr,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic [FRAME_BITS-1:0] dac_value,
    output logic                  ldac_pulse,
    output logic                  frame_err,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic                  busy
);

    // Bit counter must hold FRAME_BITS+1 so long frames stay distinguishable.
    localparam int BC_W = $clog2(FRAME_BITS + 2);
    localparam logic [BC_W-1:0] BITS_FULL = BC_W'(FRAME_BITS);
    localparam logic [BC_W-1:0] BITS_SAT  = BC_W'(FRAME_BITS + 1);

    // Link bit order inside the vectors: {ldac_n, din, sclk, cs_n}.
    // Reset value equals the idle link so leaving reset produces no edge.
    localparam logic [3:0] LINK_IDLE = 4'b1001;

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [3:0]            link_in;
    logic [3:0]            sync1_reg;
    logic [3:0]            sync2_reg;
    logic [3:0]            hist_reg;
    logic                  cs_fall_reg;
    logic                  cs_rise_reg;
    logic                  sclk_rise_reg;
    logic                  ldac_fall_reg;
    logic                  din_reg;
    state_t                state_reg;
    state_t                state_next;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [BC_W-1:0]       bit_cnt_reg;
    logic                  frame_done;
    logic                  frame_bad;

    assign link_in = {dac_ldac_n, dac_din, dac_sclk, dac_cs_n};
    assign busy    = (state_reg == SHIFT);

    // Two-flop synchronizer plus history flop for edge detection.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            sync1_reg <= LINK_IDLE;
            sync2_reg <= LINK_IDLE;
            hist_reg  <= LINK_IDLE;
        end else begin
            sync1_reg <= link_in;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    // Registered edge strobes; DIN is captured alongside so it lines up with the SCLK strobe.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cs_fall_reg   <= 1'b0;
            cs_rise_reg   <= 1'b0;
            sclk_rise_reg <= 1'b0;
            ldac_fall_reg <= 1'b0;
            din_reg       <= 1'b0;
        end else begin
            cs_fall_reg   <= hist_reg[0] & ~sync2_reg[0];
            cs_rise_reg   <= ~hist_reg[0] & sync2_reg[0];
            sclk_rise_reg <= ~hist_reg[1] & sync2_reg[1];
            ldac_fall_reg <= hist_reg[3] & ~sync2_reg[3];
            din_reg       <= sync2_reg[2];
        end
    end

    // FSM state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and frame-close classification.
    always_comb begin
        state_next = state_reg;
        frame_done = 1'b0;
        frame_bad  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cs_fall_reg) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise_reg) begin
                    state_next = IDLE;
                    frame_done = (bit_cnt_reg == BITS_FULL);
                    frame_bad  = (bit_cnt_reg != BITS_FULL);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register and saturating bit counter; a CS_N rise outranks a coincident SCLK rise.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (cs_fall_reg) begin
                shift_reg   <= '0;
                bit_cnt_reg <= '0;
            end
        end else if (sclk_rise_reg && !cs_rise_reg) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], din_reg};
            if (bit_cnt_reg != BITS_SAT) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    // Frame results, LDAC transfer and the sticky error flag.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_count <= '0;
            dac_value   <= '0;
            ldac_pulse  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            ldac_pulse  <= ldac_fall_reg;
            if (frame_done) begin
                frame_data  <= shift_reg;
                frame_count <= frame_count + CNT_WIDTH'(1);
            end
            if (ldac_fall_reg) begin
                dac_value <= frame_done ? shift_reg : frame_data;
            end
            if (frame_bad) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pmod_dac_rx.sv
// Testbench for pmod_dac_rx: directed link scenarios plus randomized frames,
// checked against a frame-level reference model.
module tb_pmod_dac_rx;

    localparam int FB = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs_n, sclk, din, ldac_n, err_clr;
    logic [FB-1:0] frame_data, dac_value;
    logic          frame_valid, ldac_pulse, frame_err, busy;
    logic [CW-1:0] frame_count;

    int compared   = 0;
    int mismatched = 0;

    // Observed pulse statistics, sampled away from the active edge.
    int   valid_seen = 0;
    int   ldac_seen  = 0;
    int   wide_pulse = 0;
    logic fv_prev    = 1'b0;
    logic lp_prev    = 1'b0;

    // Reference model: frame-level view of what the receiver should report.
    logic [FB-1:0] exp_data;
    logic [FB-1:0] exp_dac;
    logic          exp_err;
    int            exp_count;
    int            exp_valid = 0;
    int            exp_ldac  = 0;

    always #5 clk = ~clk;

    pmod_dac_rx #(.FRAME_BITS(FB), .CNT_WIDTH(CW)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .dac_cs_n     (cs_n),
        .dac_sclk     (sclk),
        .dac_din      (din),
        .dac_ldac_n   (ldac_n),
        .err_clr      (err_clr),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .dac_value    (dac_value),
        .ldac_pulse   (ldac_pulse),
        .frame_err    (frame_err),
        .frame_count  (frame_count),
        .busy         (busy)
    );

    always @(negedge clk) begin
        if (frame_valid) valid_seen <= valid_seen + 1;
        if (ldac_pulse) ldac_seen <= ldac_seen + 1;
        if ((frame_valid && fv_prev) || (ldac_pulse && lp_prev)) wide_pulse <= wide_pulse + 1;
        fv_prev <= frame_valid;
        lp_prev <= ldac_pulse;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".frame_data"}, 64'(frame_data), 64'(exp_data));
        check({tag, ".dac_value"}, 64'(dac_value), 64'(exp_dac));
        check({tag, ".frame_err"}, 64'(frame_err), 64'(exp_err));
        check({tag, ".frame_count"}, 64'(frame_count), 64'(exp_count));
        check({tag, ".valid_pulses"}, 64'(valid_seen), 64'(exp_valid));
        check({tag, ".ldac_pulses"}, 64'(ldac_seen), 64'(exp_ldac));
        check({tag, ".busy_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic model_reset();
        exp_data  = '0;
        exp_dac   = '0;
        exp_err   = 1'b0;
        exp_count = 0;
    endtask

    // Model: only a frame of exactly FB bits is accepted.
    task automatic model_frame(input logic [31:0] data, input int nbits);
        if (nbits == FB) begin
            exp_data  = data[FB-1:0];
            exp_count = (exp_count + 1) % (1 << CW);
            exp_valid++;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic link_idle();
        cs_n = 1'b1; sclk = 1'b0; din = 1'b0; ldac_n = 1'b1; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        link_idle();
        tick(1);
        rst_n = 1'b1;
        tick(2);
        model_reset();
    endtask

    task automatic send_bits(input logic [31:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            din = data[nbits-1-i];
            tick(4);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    // One frame on the link; optionally err_clr lands in the error-set cycle,
    // optionally LDAC_N falls together with CS_N rising.
    task automatic send_frame(input string tag, input logic [31:0] data, input int nbits,
                              input bit clr_align, input bit ldac_together);
        cs_n = 1'b0;
        tick(4);
        send_bits(data, nbits);
        tick(4);
        check({tag, ".busy_open"}, 64'(busy), 64'(1));
        cs_n = 1'b1;
        if (ldac_together) ldac_n = 1'b0;
        if (clr_align) begin
            tick(3);
            err_clr = 1'b1;
            tick(1);
            err_clr = 1'b0;
            tick(6);
        end else begin
            tick(10);
        end
        ldac_n = 1'b1;
        tick(6);
        model_frame(data, nbits);
        if (ldac_together) begin
            exp_dac = exp_data;
            exp_ldac++;
        end
    endtask

    task automatic pulse_ldac();
        ldac_n = 1'b0;
        tick(5);
        ldac_n = 1'b1;
        tick(8);
        exp_dac = exp_data;
        exp_ldac++;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(2);
        exp_err = 1'b0;
    endtask

    initial begin
        logic [31:0] rdata;
        int          r;
        int          nbits;

        link_idle();
        model_reset();
        do_reset();

        // Idle after reset: every output stays zero, no pulses.
        for (int i = 0; i < 20; i++) begin
            check("reset_idle", {frame_data, frame_valid, dac_value, ldac_pulse, frame_err,
                                 frame_count, busy}, 64'(0));
            tick(1);
        end

        send_frame("frame_a5c3", 32'hA5C3, 16, 1'b0, 1'b0);
        check_all("frame_a5c3");

        send_frame("frame_1234", 32'h1234, 16, 1'b0, 1'b0);
        pulse_ldac();
        check_all("ldac_1234");

        send_frame("frame_ffff", 32'hFFFF, 16, 1'b0, 1'b0);
        check_all("no_ldac_ffff");

        send_frame("short15", 32'h2AAA, 15, 1'b0, 1'b0);
        check_all("short15");
        send_frame("long17", 32'h1BEEF, 17, 1'b0, 1'b0);
        check_all("long17");
        pulse_clr();
        check_all("err_clr");

        // Error and clear in the same cycle: error must win.
        send_frame("clr_vs_err", 32'h00FF, 12, 1'b1, 1'b0);
        check_all("clr_vs_err");
        pulse_clr();

        // LDAC falling together with frame completion takes the new word.
        send_frame("ldac_same", 32'hC0DE, 16, 1'b0, 1'b1);
        check_all("ldac_same");

        // Reset in the middle of a frame, then a clean frame.
        cs_n = 1'b0;
        tick(4);
        send_bits(32'h00FF, 8);
        rst_n = 1'b0;
        tick(2);
        link_idle();
        tick(1);
        rst_n = 1'b1;
        tick(2);
        model_reset();
        check_all("mid_reset");
        send_frame("frame_0f0f", 32'h0F0F, 16, 1'b0, 1'b0);
        check_all("frame_0f0f");

        // Counter wrap: 17 good frames from reset on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_frame("wrap", $urandom, 16, 1'b0, 1'b0);
        end
        check_all("wrap17");

        // Randomized frames of mixed length with random LDAC and err_clr.
        for (int i = 0; i < 25; i++) begin
            rdata = $urandom;
            r = $urandom_range(0, 9);
            nbits = (r < 6) ? 16 : (r == 6) ? 15 : (r == 7) ? 17 : (r == 8) ? 8 : 0;
            send_frame("rand", rdata, nbits, 1'b0, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) pulse_ldac();
            if ($urandom_range(0, 2) == 0) pulse_clr();
            check_all("rand");
        end

        check("pulse_width", 64'(wide_pulse), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
